fetch_unit: RTL and testbench
=============================

Name: fetch_unit

Overview:
- Parametrised instruction-fetch engine for the MIPS core; successor to the fixed-width, state-strobed fetch stage.
- Owns the PC and issues word-addressed requests to instruction memory over a ready/valid handshake, tolerating multi-cycle memory latency.
- Presents each fetched instruction, its PC and PC+step to decode through a valid/ready handshake.
- Accepts branch/jump redirects at any time and discards wrong-path responses.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INSTR_W, 32, instruction width.
- PC_STEP, 1, PC increment per instruction (1 = word addressing, 4 = byte addressing).
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_en  in  1  permits new fetch requests; replaces the old PC enable.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_pc  in  ADDR_W  redirect target.
- imem_req  out  1  memory request valid.
- imem_addr  out  ADDR_W  request address.
- imem_ready  in  1  memory accepts request this cycle.
- imem_rvalid  in  1  response data valid.
- imem_rdata  in  INSTR_W  response instruction.
- instr_valid  out  1  instruction available to decode.
- instr_ready  in  1  decode accepts instruction.
- instr  out  INSTR_W  fetched instruction.
- instr_pc  out  ADDR_W  PC of instr.
- pc_next  out  ADDR_W  instr_pc + PC_STEP.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM enters IDLE; pc=RESET_PC; drop=0.
  - imem_req=0, imem_addr=RESET_PC.
  - instr_valid=0, instr=0, instr_pc=0, pc_next=0.
- Reset asserted mid-operation: any outstanding request is forgotten. The memory side must also be reset.
- All outputs are registered, Moore style. imem_addr always equals pc.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - fetch_en=1 -> REQ.
  - redirect_valid -> pc<=redirect_pc; stay in IDLE unless fetch_en=1.
- REQ:
  - imem_req=1, held until imem_ready. A request is never withdrawn, even if fetch_en falls.
  - imem_ready=1 -> WAIT.
  - redirect_valid before acceptance -> pc<=redirect_pc; stay in REQ; address changes next cycle.
  - redirect in the same cycle as imem_ready -> go to WAIT, set drop=1, pc<=redirect_pc.
- WAIT:
  - imem_req=0. Response latency is at least 1 cycle after acceptance; it may be unbounded.
  - imem_rvalid with drop=1 -> discard the data; drop<=0; go to REQ if fetch_en=1, else IDLE.
  - imem_rvalid with drop=0 -> instr<=imem_rdata, instr_pc<=pc, pc_next<=pc+PC_STEP, pc<=pc+PC_STEP, instr_valid<=1 -> HOLD.
  - redirect_valid in WAIT -> pc<=redirect_pc, drop<=1. If it coincides with imem_rvalid, the data is discarded.
- HOLD:
  - instr, instr_pc and pc_next are stable while instr_valid=1 and instr_ready=0.
  - instr_valid & instr_ready -> instr_valid<=0; go to REQ if fetch_en=1, else IDLE.
  - redirect_valid without handshake -> kill: instr_valid<=0, pc<=redirect_pc -> REQ.
  - redirect_valid coincident with handshake -> the instruction counts as consumed; pc<=redirect_pc.
- Arithmetic: PC addition is modulo 2^ADDR_W, so pc = 2^ADDR_W - PC_STEP wraps to 0. No overflow flag.
- At most one outstanding memory request. Minimum latency from fetch_en to instr_valid is 3 cycles (imem_ready=1, rvalid one cycle later).
- Outputs with X/Z on imem_rdata while rvalid=0 are ignored.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs perf_fetched[31:0] and perf_killed[31:0].
  - perf_fetched counts completed decode handshakes.
  - perf_killed counts discarded responses plus instructions killed in HOLD.
  - Both saturate at 2^32-1 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package fetch_pkg holds:
  - the FSM state enum (IDLE=2'd0, REQ=2'd1, WAIT=2'd2, HOLD=2'd3);
  - default width constants;
  - RESET_PC default.
- One natural sub-module: fetch_pc_reg, the PC register with increment, redirect load and asynchronous active-low reset.
- FSM and output registers stay in fetch_unit.

Test Plan:
- Reset then fetch_en=1, imem_ready=1, 1-cycle memory returning 0x20080005 at address 0 -> instr_valid in cycle 3, instr=0x20080005, instr_pc=0, pc_next=1. The next request is to address 1.
- Memory stalls imem_ready low for 4 cycles, then 3-cycle rvalid latency -> imem_req held stable on address 5 throughout; exactly one instr delivered.
- redirect_valid with redirect_pc=0x40 while in WAIT at pc=7 -> the response for 7 is discarded (instr_valid stays 0); the next imem_addr is 0x40.
- Decode holds instr_ready=0 for 5 cycles, then a redirect to 0x100 -> instr stable for 5 cycles, instr_valid dropped, next request to 0x100.
- PC_STEP=4, ADDR_W=8, redirect to 0xFC -> after the fetch, pc_next=0x00 and the next request goes to 0x00.
- Assert reset mid-WAIT -> all outputs return to their reset values asynchronously; after release, the first request is to RESET_PC. With FETCH_PERF_CNT_EN defined, the counters read 0.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch engine.
// FSM state encoding plus default widths and reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } fetch_state_t;

  localparam int unsigned DEF_ADDR_W   = 32;
  localparam int unsigned DEF_INSTR_W  = 32;
  localparam int unsigned DEF_PC_STEP  = 1;
  localparam logic [31:0] DEF_RESET_PC = 32'h0;

endpackage

// File: rtl/fetch_pc_reg.sv
// Program counter: redirect load has priority over increment.
// Increment wraps modulo 2^ADDR_W.
module fetch_pc_reg
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       PC_STEP  = DEF_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_pc,
  input  logic              inc,
  output logic [ADDR_W-1:0] pc
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + STEP;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch engine: one outstanding imem request, redirects, decode handshake.
// Define FETCH_PERF_CNT_EN to add saturating perf_fetched/perf_killed counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = DEF_ADDR_W,
  parameter int unsigned       INSTR_W  = DEF_INSTR_W,
  parameter int unsigned       PC_STEP  = DEF_PC_STEP,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_en,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic [ADDR_W-1:0]  pc_next
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_killed
`endif
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(PC_STEP);

  fetch_state_t      state;
  logic              drop;
  logic [ADDR_W-1:0] pc;
  logic              resp;
  logic              deliver;

  assign resp      = (state == WAIT) && imem_rvalid;
  // A redirect landing with the response also makes it wrong-path.
  assign deliver   = resp && !drop && !redirect_valid;
  assign imem_addr = pc;

  fetch_pc_reg #(
    .ADDR_W   (ADDR_W),
    .PC_STEP  (PC_STEP),
    .RESET_PC (RESET_PC)
  ) u_pc (
    .clk     (clk),
    .rst_n   (reset),
    .load    (redirect_valid),
    .load_pc (redirect_pc),
    .inc     (deliver),
    .pc      (pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      drop        <= 1'b0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      pc_next     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (fetch_en) begin
            state    <= REQ;
            imem_req <= 1'b1;
          end
        end
        REQ: begin
          if (imem_ready) begin
            state    <= WAIT;
            imem_req <= 1'b0;
            drop     <= redirect_valid;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop <= 1'b0;
            if (deliver) begin
              instr       <= imem_rdata;
              instr_pc    <= pc;
              pc_next     <= pc + STEP;
              instr_valid <= 1'b1;
              state       <= HOLD;
            end else begin
              state    <= fetch_en ? REQ : IDLE;
              imem_req <= fetch_en;
            end
          end else if (redirect_valid) begin
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            state       <= fetch_en ? REQ : IDLE;
            imem_req    <= fetch_en;
          end else if (redirect_valid) begin
            instr_valid <= 1'b0;
            state       <= REQ;
            imem_req    <= 1'b1;
          end
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic hs;
  logic kill;

  assign hs   = (state == HOLD) && instr_ready;
  assign kill = (resp && !deliver) ||
                ((state == HOLD) && !instr_ready && redirect_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_fetched <= '0;
      perf_killed  <= '0;
    end else begin
      if (hs && (perf_fetched != '1)) begin
        perf_fetched <= perf_fetched + 32'd1;
      end
      if (kill && (perf_killed != '1)) begin
        perf_killed <= perf_killed + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized scoreboard bench for fetch_unit (8-bit byte-addressed PC).
// Expected instructions are queued at request acceptance and popped at decode handshake.
module tb_fetch_unit;

  localparam int          AW     = 8;
  localparam int          IW     = 32;
  localparam int          STEP   = 4;
  localparam logic [7:0]  RST_PC = 8'hF0;

  logic          clk;
  logic          reset;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_pc;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ready;
  logic          imem_rvalid;
  logic [IW-1:0] imem_rdata;
  logic          instr_valid;
  logic          instr_ready;
  logic [IW-1:0] instr;
  logic [AW-1:0] instr_pc;
  logic [AW-1:0] pc_next;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]   perf_fetched;
  logic [31:0]   perf_killed;
`endif

  fetch_unit #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .PC_STEP  (STEP),
    .RESET_PC (RST_PC)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .pc_next        (pc_next)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_killed    (perf_killed)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] instr;
    logic [AW-1:0] pc;
    logic [AW-1:0] nxt;
  } item_t;

  item_t         q[$];
  int            checks = 0;
  int            errors = 0;
  int            n_acc  = 0;
  int            n_hs   = 0;
  logic [AW-1:0] exp_pc = RST_PC;

  bit            acc_flag = 0;
  logic [AW-1:0] acc_addr;
  bit            pending  = 0;
  logic [AW-1:0] pend_addr;
  int            lat;

  int p_ready, p_redir, p_iready, p_fetch, lat_min, lat_max;

  function automatic logic [IW-1:0] mem_word(logic [AW-1:0] a);
    return {a ^ 8'h3C, ~a, a, 8'hA5};
  endfunction

  function automatic bit pct(int p);
    return $urandom_range(0, 99) < p;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard / monitor: samples on the falling edge.
  always @(negedge clk) begin
    if (!reset) begin
      q.delete();
      exp_pc = RST_PC;
    end else begin
      if (instr_valid) begin
        if (q.size() == 0) begin
          chk("valid_without_request", 64'(q.size()), 64'd1);
        end else begin
          chk("instr", instr, q[0].instr);
          chk("instr_pc", instr_pc, q[0].pc);
          chk("pc_next", pc_next, q[0].nxt);
          if (instr_ready) begin
            void'(q.pop_front());
            n_hs++;
          end
        end
      end
      if (imem_req && imem_ready) begin
        chk("imem_addr", imem_addr, exp_pc);
        chk("one_outstanding", 64'(pending || imem_rvalid), 64'd0);
        n_acc++;
        acc_flag = 1;
        acc_addr = imem_addr;
        if (!redirect_valid) begin
          q.push_back('{mem_word(exp_pc), exp_pc, exp_pc + 8'(STEP)});
          exp_pc = exp_pc + 8'(STEP);
        end
      end
      if (redirect_valid) begin
        q.delete();
        exp_pc = redirect_pc;
      end
    end
  end

  // One clock of stimulus plus the memory responder.
  task automatic step();
    @(posedge clk);
    #1;
    if (acc_flag) begin
      acc_flag  = 0;
      pending   = 1;
      pend_addr = acc_addr;
      lat       = $urandom_range(lat_min, lat_max);
    end
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (pending) begin
      lat--;
      if (lat <= 0) begin
        pending     = 0;
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pend_addr);
      end
    end
    imem_ready     = pct(p_ready);
    instr_ready    = pct(p_iready);
    fetch_en       = pct(p_fetch);
    redirect_valid = pct(p_redir);
    redirect_pc    = ($urandom_range(0, 3) == 0) ? 8'hFC
                                                 : 8'($urandom_range(0, 63) * 4);
  endtask

  initial begin
    reset = 1'b0;
    fetch_en = 0; redirect_valid = 0; redirect_pc = '0;
    imem_ready = 0; imem_rvalid = 0; imem_rdata = '0; instr_ready = 0;
    p_ready = 100; p_redir = 0; p_iready = 0; p_fetch = 100;
    lat_min = 1; lat_max = 1;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_imem_req", imem_req, 1'b0);
    chk("rst_imem_addr", imem_addr, RST_PC);
    chk("rst_instr_valid", instr_valid, 1'b0);
    chk("rst_instr", instr, 0);
    chk("rst_instr_pc", instr_pc, 0);
    chk("rst_pc_next", pc_next, 0);

    // First fetch: valid exactly three edges after fetch_en.
    reset = 1'b1;
    fetch_en = 1'b1;
    imem_ready = 1'b1;
    step();
    step();
    chk("first_latency_early", instr_valid, 1'b0);
    step();
    chk("first_latency", instr_valid, 1'b1);
    chk("first_instr", instr, mem_word(RST_PC));
    chk("first_pc_next", pc_next, 8'hF4);

    // Stall acceptance for 4 cycles: request must hold steady.
    p_iready = 100; p_ready = 0;
    instr_ready = 1'b1; imem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("stall_req", imem_req, 1'b1);
      chk("stall_addr", imem_addr, 8'hF4);
    end
    p_ready = 100; lat_min = 3; lat_max = 3;
    repeat (12) step();

    // Randomized phases.
    for (int ph = 0; ph < 6; ph++) begin
      p_ready  = $urandom_range(30, 100);
      p_redir  = $urandom_range(0, 20);
      p_iready = $urandom_range(20, 100);
      p_fetch  = $urandom_range(50, 100);
      lat_min  = 1;
      lat_max  = $urandom_range(1, 6);
      repeat (400) step();
    end

    // Drain.
    p_fetch = 0; p_redir = 0; p_iready = 100; p_ready = 100;
    repeat (40) step();
    chk("drain_queue", 64'(q.size()), 0);
    chk("drain_valid", instr_valid, 1'b0);
    chk("delivered_some", 64'(n_hs > 50), 1);
`ifdef FETCH_PERF_CNT_EN
    chk("perf_fetched", perf_fetched, 64'(n_hs));
    chk("perf_killed", perf_killed, 64'(n_acc - n_hs));
`endif

    // Reset while a long-latency response is outstanding.
    p_fetch = 100; p_ready = 100; p_iready = 0;
    lat_min = 10; lat_max = 10;
    repeat (4) step();
    #2;
    reset = 1'b0;
    pending = 0;
    acc_flag = 0;
    #1;
    chk("mid_rst_imem_req", imem_req, 1'b0);
    chk("mid_rst_imem_addr", imem_addr, RST_PC);
    chk("mid_rst_instr_valid", instr_valid, 1'b0);
    chk("mid_rst_instr", instr, 0);
    chk("mid_rst_instr_pc", instr_pc, 0);
    chk("mid_rst_pc_next", pc_next, 0);
`ifdef FETCH_PERF_CNT_EN
    chk("mid_rst_perf_fetched", perf_fetched, 0);
    chk("mid_rst_perf_killed", perf_killed, 0);
`endif
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    p_ready = 0;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    fetch_en = 1'b1;
    step();
    chk("post_rst_req", imem_req, 1'b1);
    chk("post_rst_addr", imem_addr, RST_PC);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
